// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/bubble sequencing for the 5-stage pipeline: load-use, taken branches, memory waits with a timeout watchdog.
// Define HAZ_PERF_CNT_EN to build the StallCycles/FlushCycles performance counters; otherwise both read 0.
module pipe_hazard_ctrl #(
    parameter int BRANCH_PENALTY = 1,
    parameter int MEM_WAIT_MAX   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        BranchTaken,
    input  logic        MemStallReq,
    output logic        PC_WriteEn,
    output logic        IFID_WriteEn,
    output logic        IFID_BeqFlush,
    output logic        IDEX_Bubble,
    output logic        WaitTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles
);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_e;

    localparam logic [1:0] FLUSH_INIT  = 2'(BRANCH_PENALTY - 1);
    localparam logic [7:0] WAIT_MAX    = 8'(MEM_WAIT_MAX);
    localparam bit         MULTI_FLUSH = (BRANCH_PENALTY > 1);

    state_e     state_q, state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       pend_br_q, pend_br_d;
    logic       timeout_q, timeout_d;
    logic       lu;

    assign lu = EX_MemRead && (EX_Rt != 5'd0) &&
                ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        pend_br_d     = pend_br_q;
        timeout_d     = timeout_q;
        PC_WriteEn    = 1'b1;
        IFID_WriteEn  = 1'b1;
        IFID_BeqFlush = 1'b0;
        IDEX_Bubble   = 1'b0;

        case (state_q)
            RUN: begin
                if (MemStallReq) begin
                    PC_WriteEn   = 1'b0;
                    IFID_WriteEn = 1'b0;
                    IDEX_Bubble  = 1'b1;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = 8'd1;
                    pend_br_d    = BranchTaken;
                end else if (BranchTaken) begin
                    IFID_BeqFlush = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end else if (lu) begin
                    PC_WriteEn   = 1'b0;
                    IFID_WriteEn = 1'b0;
                    IDEX_Bubble  = 1'b1;
                end
            end
            FLUSH: begin
                IFID_BeqFlush = 1'b1;
                IDEX_Bubble   = 1'b1;
                if (MemStallReq) begin
                    PC_WriteEn   = 1'b0;
                    IFID_WriteEn = 1'b0;
                end else if (flush_cnt_q <= 2'd1) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            MEM_WAIT: begin
                if (MemStallReq) begin
                    PC_WriteEn   = 1'b0;
                    IFID_WriteEn = 1'b0;
                    IDEX_Bubble  = 1'b1;
                    if (wait_cnt_q >= WAIT_MAX) begin
                        timeout_d     = 1'b1;
                        IFID_BeqFlush = 1'b1;
                        state_d       = RUN;
                        pend_br_d     = 1'b0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                        pend_br_d  = pend_br_q | BranchTaken;
                    end
                end else begin
                    // A branch resolved on the exit cycle itself is honoured too.
                    state_d   = RUN;
                    pend_br_d = 1'b0;
                    if (pend_br_q || BranchTaken) begin
                        IFID_BeqFlush = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_d     = FLUSH;
                            flush_cnt_d = FLUSH_INIT;
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            PC_WriteEn    = 1'b0;
            IFID_WriteEn  = 1'b0;
            IFID_BeqFlush = 1'b1;
            IDEX_Bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 2'd0;
            wait_cnt_q  <= 8'd0;
            pend_br_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            pend_br_q   <= pend_br_d;
            timeout_q   <= timeout_d;
        end
    end

    assign WaitTimeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cyc_q, flush_cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cyc_q <= 32'd0;
            flush_cyc_q <= 32'd0;
        end else begin
            if (!PC_WriteEn)   stall_cyc_q <= stall_cyc_q + 32'd1;
            if (IFID_BeqFlush) flush_cyc_q <= flush_cyc_q + 32'd1;
        end
    end

    assign StallCycles = stall_cyc_q;
    assign FlushCycles = flush_cyc_q;
`else
    assign StallCycles = 32'd0;
    assign FlushCycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int BP   = 2;
    localparam int MAXW = 4;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst;
    logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
    logic        ID_UsesRt, EX_MemRead, BranchTaken, MemStallReq;
    logic        PC_WriteEn, IFID_WriteEn, IFID_BeqFlush, IDEX_Bubble, WaitTimeout;
    logic [31:0] StallCycles, FlushCycles;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(.BRANCH_PENALTY(BP), .MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .BranchTaken(BranchTaken),
        .MemStallReq(MemStallReq), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .IFID_BeqFlush(IFID_BeqFlush), .IDEX_Bubble(IDEX_Bubble), .WaitTimeout(WaitTimeout),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: mode is "waiting", "flush_left > 0" or plain running.
    bit          m_waiting, m_pend, m_timeout;
    int          m_waited, m_flush_left;
    logic [31:0] m_stall, m_flc;
    logic        e_pc, e_ifid, e_fl, e_bub;

    function automatic logic [3:0] dut_out();
        return {PC_WriteEn, IFID_WriteEn, IFID_BeqFlush, IDEX_Bubble};
    endfunction

    task automatic model_comb();
        bit lu;
        lu = EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt));
        {e_pc, e_ifid, e_fl, e_bub} = 4'b1100;
        if (rst) begin
            {e_pc, e_ifid, e_fl, e_bub} = 4'b0011;
        end else if (m_waiting) begin
            if (MemStallReq) {e_pc, e_ifid, e_fl, e_bub} = {3'b000, 1'b1} | {2'b00, (m_waited == MAXW), 1'b0};
            else             {e_pc, e_ifid, e_fl, e_bub} = {2'b11, (m_pend || BranchTaken), 1'b0};
        end else if (m_flush_left > 0) begin
            {e_pc, e_ifid, e_fl, e_bub} = {!MemStallReq, !MemStallReq, 2'b11};
        end else if (MemStallReq || (!BranchTaken && lu)) begin
            {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
        end else if (BranchTaken) begin
            {e_pc, e_ifid, e_fl, e_bub} = 4'b1110;
        end
    endtask

    task automatic model_update();
        model_comb();
        if (rst) begin
            m_waiting = 0; m_pend = 0; m_timeout = 0; m_waited = 0; m_flush_left = 0;
            m_stall = 0; m_flc = 0;
            return;
        end
        if (!e_pc) m_stall = m_stall + 1;
        if (e_fl)  m_flc   = m_flc + 1;
        if (m_waiting) begin
            if (MemStallReq) begin
                if (m_waited == MAXW) begin
                    m_timeout = 1; m_waiting = 0; m_pend = 0;
                end else begin
                    m_waited++;
                    m_pend = m_pend || BranchTaken;
                end
            end else begin
                m_waiting = 0;
                if (m_pend || BranchTaken) m_flush_left = BP - 1;
                m_pend = 0;
            end
        end else if (m_flush_left > 0) begin
            if (!MemStallReq) m_flush_left--;
        end else if (MemStallReq) begin
            m_waiting = 1; m_waited = 1; m_pend = BranchTaken;
        end else if (BranchTaken) begin
            m_flush_left = BP - 1;
        end
    endtask

    task automatic set_in(input bit r, input bit st, input bit br, input bit mr,
                          input bit ur, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] ert);
        rst = r; MemStallReq = st; BranchTaken = br; EX_MemRead = mr;
        ID_UsesRt = ur; ID_Rs = rs; ID_Rt = rt; EX_Rt = ert;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        advance();
        @(negedge clk);
        n_tests++;
        if (dut_out() !== 4'b0011) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0011", dut_out());
        end
        n_tests++;
        if (WaitTimeout !== 1'b0 || StallCycles !== 32'd0 || FlushCycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_state: timeout=%b stall=%0d flush=%0d want 0/0/0",
                               WaitTimeout, StallCycles, FlushCycles);
        end
        advance();
    endtask

    task automatic test_load_use();
        set_in(0, 0, 0, 1, 0, 5, 0, 5);
        @(negedge clk);
        n_tests++;
        if (dut_out() !== 4'b0001) begin
            n_fail++; $display("FAIL load_use_stall: got %b want 0001", dut_out());
        end
        advance();
        set_in(0, 0, 0, 0, 0, 5, 0, 5);
        @(negedge clk);
        n_tests++;
        if (dut_out() !== 4'b1100) begin
            n_fail++; $display("FAIL load_use_one_cycle: got %b want 1100", dut_out());
        end
        advance();
        set_in(0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (dut_out() !== 4'b1100) begin
            n_fail++; $display("FAIL load_use_r0: got %b want 1100", dut_out());
        end
        advance();
        set_in(0, 0, 0, 1, 1, 3, 7, 7);
        @(negedge clk);
        n_tests++;
        if (dut_out() !== 4'b0001) begin
            n_fail++; $display("FAIL load_use_rt: got %b want 0001", dut_out());
        end
        advance();
    endtask

    task automatic test_branch();
        logic [3:0] want [3] = '{4'b1110, 4'b1111, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, (i == 0), 0, 0, 0, 0, 0);
            @(negedge clk);
            n_tests++;
            if (dut_out() !== want[i]) begin
                n_fail++; $display("FAIL branch_c%0d: got %b want %b", i, dut_out(), want[i]);
            end
            advance();
        end
    endtask

    task automatic test_mem_wait_pending();
        logic [3:0] want [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1110, 4'b1111, 4'b1100};
        for (int i = 0; i < 7; i++) begin
            set_in(0, (i < 4), (i == 1), 0, 0, 0, 0, 0);
            @(negedge clk);
            n_tests++;
            if (dut_out() !== want[i]) begin
                n_fail++; $display("FAIL memwait_pend_c%0d: got %b want %b", i, dut_out(), want[i]);
            end
            advance();
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] want [5] = '{4'b0001, 4'b0001, 4'b1110, 4'b1111, 4'b1100};
        for (int i = 0; i < 5; i++) begin
            set_in(0, (i < 2), (i == 0), (i == 0), 0, 9, 0, 9);
            @(negedge clk);
            n_tests++;
            if (dut_out() !== want[i]) begin
                n_fail++; $display("FAIL simultaneous_c%0d: got %b want %b", i, dut_out(), want[i]);
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 13; k++) begin
            set_in(0, (k < 10), 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            n_tests++;
            if (k < 10 && dut_out() !== {3'b000, 1'b1} + {2'b00, (k == 4 || k == 9), 1'b0}) begin
                n_fail++; $display("FAIL timeout_out_c%0d: got %b", k, dut_out());
            end else if (k >= 10 && dut_out() !== 4'b1100) begin
                n_fail++; $display("FAIL timeout_release_c%0d: got %b want 1100", k, dut_out());
            end
            n_tests++;
            if (WaitTimeout !== (k >= 5)) begin
                n_fail++; $display("FAIL timeout_flag_c%0d: got %b want %b", k, WaitTimeout, (k >= 5));
            end
            advance();
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (WaitTimeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear: got %b want 0", WaitTimeout);
        end
        advance();
    endtask

    task automatic test_reset_mid_flush();
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        advance();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (dut_out() !== 4'b0011) begin
            n_fail++; $display("FAIL rst_flush_forced: got %b want 0011", dut_out());
        end
        advance();
        @(negedge clk);
        n_tests++;
        if (dut_out() !== 4'b0011 || StallCycles !== 32'd0 || FlushCycles !== 32'd0) begin
            n_fail++; $display("FAIL rst_flush_hold: out=%b stall=%0d flush=%0d want 0011/0/0",
                               dut_out(), StallCycles, FlushCycles);
        end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (dut_out() !== 4'b1100) begin
            n_fail++; $display("FAIL rst_flush_run: got %b want 1100", dut_out());
        end
        advance();
    endtask

    task automatic test_random();
        bit st = 0;
        for (int c = 0; c < 800; c++) begin
            st = st ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
            set_in(($urandom_range(0, 59) == 0), st, ($urandom_range(0, 6) == 0),
                   $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            @(negedge clk);
            model_comb();
            n_tests++;
            if (dut_out() !== {e_pc, e_ifid, e_fl, e_bub}) begin
                n_fail++; $display("FAIL random_out_c%0d: got %b want %b", c, dut_out(),
                                   {e_pc, e_ifid, e_fl, e_bub});
            end
            n_tests++;
            if (WaitTimeout !== m_timeout) begin
                n_fail++; $display("FAIL random_timeout_c%0d: got %b want %b", c, WaitTimeout, m_timeout);
            end
            n_tests++;
            if (StallCycles !== (PERF ? m_stall : 32'd0) || FlushCycles !== (PERF ? m_flc : 32'd0)) begin
                n_fail++; $display("FAIL random_perf_c%0d: stall=%0d flush=%0d want %0d/%0d", c,
                                   StallCycles, FlushCycles, PERF ? m_stall : 32'd0, PERF ? m_flc : 32'd0);
            end
            advance();
        end
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        advance();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait_pending();
        test_simultaneous();
        test_timeout();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU.
- Generates the PC write enable, IF/ID register write enable (IFID_WriteEn), IF/ID flush (IFID_BeqFlush) and ID/EX bubble insert.
- Handles load-use hazards, taken branches (multi-cycle flush penalty) and external memory wait requests, including a wait-timeout watchdog.

Parameters:
BRANCH_PENALTY, 1, number of consecutive cycles IFID_BeqFlush is held after a taken branch (legal 1..3)
MEM_WAIT_MAX, 16, memory-wait cycles before timeout abort (legal 2..255)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous active-high reset
ID_Rs  input  5  rs field of instruction in ID
ID_Rt  input  5  rt field of instruction in ID
ID_UsesRt  input  1  ID instruction reads rt as a source
EX_MemRead  input  1  instruction in EX is a load
EX_Rt  input  5  destination rt of load in EX
BranchTaken  input  1  branch resolved taken this cycle (single-cycle pulse)
MemStallReq  input  1  instruction/data memory not ready
PC_WriteEn  output  1  PC register update enable
IFID_WriteEn  output  1  IF/ID register write enable
IFID_BeqFlush  output  1  IF/ID register clear
IDEX_Bubble  output  1  zero control signals into ID/EX
WaitTimeout  output  1  sticky: a memory wait hit MEM_WAIT_MAX
StallCycles  output  32  perf counter (optional feature)
FlushCycles  output  32  perf counter (optional feature)

Behaviour:
- States: RUN, FLUSH, MEM_WAIT. Internal: flush_cnt (2 bits), wait_cnt (8 bits), pend_br (1 bit).
- Reset (rst=1 at posedge): state<=RUN, flush_cnt<=0, wait_cnt<=0, pend_br<=0, WaitTimeout<=0, perf counters<=0.
- While rst is high, outputs are forced: PC_WriteEn=0, IFID_WriteEn=0, IFID_BeqFlush=1, IDEX_Bubble=1.
- Outputs are combinational from the current state and inputs (zero latency). Defaults: PC_WriteEn=1, IFID_WriteEn=1, IFID_BeqFlush=0, IDEX_Bubble=0.
- Load-use hazard (lu): EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)).
- RUN, priority MemStallReq > BranchTaken > lu:
  - MemStallReq=1: PC_WriteEn=0, IFID_WriteEn=0, IDEX_Bubble=1. Next state MEM_WAIT, wait_cnt<=1, pend_br<=BranchTaken.
  - BranchTaken=1: IFID_BeqFlush=1; PC keeps writing (target). If BRANCH_PENALTY>1, next state FLUSH with flush_cnt<=BRANCH_PENALTY-1; otherwise stay in RUN.
  - lu=1: PC_WriteEn=0, IFID_WriteEn=0, IDEX_Bubble=1 for exactly this cycle; stay in RUN. The next cycle re-evaluates lu (by then EX holds the bubble).
- FLUSH: IFID_BeqFlush=1, IDEX_Bubble=1; flush_cnt decrements each cycle; return to RUN when flush_cnt==1. A BranchTaken or lu arriving in FLUSH is ignored.
  - MemStallReq in FLUSH additionally drives PC_WriteEn=0 and IFID_WriteEn=0, and freezes flush_cnt; the flush remains asserted.
- MEM_WAIT: PC_WriteEn=0, IFID_WriteEn=0, IDEX_Bubble=1; wait_cnt increments each cycle. BranchTaken seen here sets pend_br.
  - MemStallReq=0: exit. If pend_br, the exit cycle drives IFID_BeqFlush=1 and then behaves as a branch (FLUSH if BRANCH_PENALTY>1); otherwise go to RUN. pend_br<=0.
  - wait_cnt==MEM_WAIT_MAX while MemStallReq=1: WaitTimeout<=1 (sticky until rst), IFID_BeqFlush=1 for that cycle, state<=RUN, pend_br<=0.
- Timeout leaves RUN with MemStallReq still high; it re-enters MEM_WAIT on the next cycle with wait_cnt<=1.
- Reset during any state aborts immediately to RUN. No pending flush survives reset.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: StallCycles increments on every non-reset cycle with PC_WriteEn=0. FlushCycles increments on every non-reset cycle with IFID_BeqFlush=1. Both wrap at 2^32 and clear on rst.
- Undefined: no counter registers are built; StallCycles and FlushCycles are tied to 32'd0.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 for one cycle -> PC_WriteEn=0, IFID_WriteEn=0, IDEX_Bubble=1 for exactly 1 cycle. Same stimulus with EX_Rt=0 -> no stall.
- Branch: BRANCH_PENALTY=2, BranchTaken pulse -> IFID_BeqFlush=1 for 2 consecutive cycles, PC_WriteEn=1 in both.
- Memory wait with pending branch: MemStallReq high 4 cycles, BranchTaken pulse in cycle 2 -> PC frozen 4 cycles, then IFID_BeqFlush=1 on the exit cycle.
- Timeout: MEM_WAIT_MAX=4, MemStallReq held 10 cycles -> WaitTimeout rises after 4 wait cycles and stays 1; flush pulse on the timeout cycle; WaitTimeout clears only on rst.
- Simultaneous: MemStallReq=1, BranchTaken=1 and lu=1 in the same RUN cycle -> MEM_WAIT entered, pend_br=1, no flush until the wait ends.
- Reset mid-FLUSH: rst=1 during a FLUSH cycle -> next cycle state RUN; enables 0, flush 1 while rst is high; perf counters (with HAZ_PERF_CNT_EN) read 0.
